// File: rtl/gb_host_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gb_host_pkg : shared types and limits for the GhostBus sequencer |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package gb_host_pkg;

  localparam int CNT_W      = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  localparam int LAT_W      = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RSP      = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gb_lat_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gb_lat_timer : loadable read-latency countdown with done pulse   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module gb_lat_timer
  import gb_host_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAT_W'(LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  // done marks the last wait cycle, so the caller samples on that edge
  assign done = (cnt_q == LAT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gb_host_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gb_host_seq : command-to-GhostBus sequencer (writes, read bursts)|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module gb_host_seq
  import gb_host_pkg::*;
#(
  parameter int unsigned AW     = 24,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [7:0]    cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_rdata,
  output logic          busy
);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q;
  logic             lat_done;

  gb_lat_timer #(
    .LAT (RD_LAT)
  ) u_lat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (gb_re),
    .done  (lat_done)
  );

  // en_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = en_q && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign gb_we     = (state_q == ST_WR);
  assign gb_re     = (state_q == ST_RD_ISSUE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_last  = rsp_valid && (cnt_q == '0);
  assign rsp_data  = data_q;
  assign gb_addr   = addr_q;
  assign gb_wdata  = wdata_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d = cmd_addr;
          if (cmd_we) begin
            wdata_d = cmd_wdata;
            state_d = ST_WR;
          end else begin
            cnt_d   = cmd_len;
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_WR:       state_d = ST_IDLE;
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (lat_done) begin
          data_d  = gb_rdata;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + AW'(1);
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = ST_RD_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      en_q    <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gb_host_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gb_host_seq : directed self-checking bench for gb_host_seq    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_gb_host_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [7:0]  cmd_len;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic [23:0] gb_addr;
  logic [31:0] gb_wdata, gb_rdata;
  logic        gb_we, gb_re, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gb_host_seq #(.AW(24), .DW(32), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
    .gb_rdata(gb_rdata), .busy(busy)
  );

  // two-cycle bus: returns the strobed address as data, junk otherwise
  logic [31:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= gb_re ? 32'(gb_addr) : 32'hDEADBEEF;
    pipe1 <= pipe0;
  end
  assign gb_rdata = pipe1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  // event logs and protocol checks
  logic [31:0] re_q[$];
  logic [31:0] beat_data[$];
  logic        beat_last[$];
  int          we_cnt = 0;
  int          rsp_cycles = 0;
  logic [31:0] we_addr, we_data;
  logic        prev_re = 1'b0, prev_we = 1'b0;
  int          outst = 0;
  logic        live;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      outst   = 0;
      prev_re = 1'b0;
      prev_we = 1'b0;
    end else begin
      check("we_re_exclusive", 32'(gb_we && gb_re), 32'd0);
      check("re_one_cycle", 32'(prev_re && gb_re), 32'd0);
      check("we_one_cycle", 32'(prev_we && gb_we), 32'd0);
      if (live) check("ready_is_idle", 32'(cmd_ready), 32'(!busy));
      if (gb_re) begin
        check("one_outstanding", 32'(outst), 32'd0);
        check("no_re_in_rsp", 32'(rsp_valid), 32'd0);
        outst = 1;
        re_q.push_back(32'(gb_addr));
      end
      if (gb_we) begin
        we_cnt++;
        we_addr = 32'(gb_addr);
        we_data = gb_wdata;
      end
      if (rsp_valid) rsp_cycles++;
      if (rsp_valid && rsp_ready) begin
        outst = 0;
        beat_data.push_back(rsp_data);
        beat_last.push_back(rsp_last);
      end
      prev_re = gb_re;
      prev_we = gb_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap_we, snap_rsp, snap_re;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_gb_addr", 32'(gb_addr), 32'd0);
    check("rst_gb_wdata", gb_wdata, 32'd0);
    check("rst_strobes", 32'({gb_we, gb_re}), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    check("rel_ready_high", 32'(cmd_ready), 32'd1);

    // single write
    snap_rsp = rsp_cycles;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000010; cmd_wdata = 32'hceceface;
    tick();
    cmd_valid = 1'b0;
    check("wr_we", 32'(gb_we), 32'd1);
    check("wr_addr", 32'(gb_addr), 32'h10);
    check("wr_wdata", gb_wdata, 32'hceceface);
    check("wr_busy", 32'(busy), 32'd1);
    tick();
    check("wr_we_done", 32'(gb_we), 32'd0);
    check("wr_ready_back", 32'(cmd_ready), 32'd1);
    repeat (4) tick();
    check("wr_we_count", 32'(we_cnt), 32'd1);
    check("wr_no_rsp", 32'(rsp_cycles - snap_rsp), 32'd0);
    check("wr_addr_hold", 32'(gb_addr), 32'h10);
    check("wr_wdata_hold", gb_wdata, 32'hceceface);

    // four-beat read, consumer always ready
    re_q.delete(); beat_data.delete(); beat_last.delete();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000100; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    check("rd_re_n1", 32'(gb_re), 32'd1);
    check("rd_addr_n1", 32'(gb_addr), 32'h100);
    tick();
    check("rd_re_n2", 32'(gb_re), 32'd0);
    tick();
    check("rd_wait_n3", 32'(rsp_valid), 32'd0);
    tick();
    check("rd_valid_n4", 32'(rsp_valid), 32'd1);
    check("rd_data_n4", rsp_data, 32'h100);
    wait_idle("rd_timeout");
    check("rd_re_count", 32'(re_q.size()), 32'd4);
    check("rd_beat_count", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < re_q.size())      check("rd_re_addr", re_q[i], 32'h100 + 32'(i));
      if (i < beat_data.size()) check("rd_beat_data", beat_data[i], 32'h100 + 32'(i));
      if (i < beat_last.size()) check("rd_beat_last", 32'(beat_last[i]), 32'(i == 3));
    end

    // same burst, five-cycle stall on beat 1
    re_q.delete(); beat_data.delete(); beat_last.delete();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000100; cmd_len = 8'd3;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    check("st_beat0_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    snap_re = re_q.size();
    for (int i = 0; i < 5; i++) begin
      check("st_valid", 32'(rsp_valid), 32'd1);
      check("st_data", rsp_data, 32'h101);
      check("st_last", 32'(rsp_last), 32'd0);
      tick();
    end
    check("st_no_re", 32'(re_q.size()), 32'(snap_re));
    rsp_ready = 1'b1;
    wait_idle("st_timeout");
    check("st_beat_count", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_data.size()) check("st_beat_data", beat_data[i], 32'h100 + 32'(i));
      if (i < beat_last.size()) check("st_beat_last", 32'(beat_last[i]), 32'(i == 3));
    end

    // address wrap at the top of the space
    re_q.delete(); beat_data.delete(); beat_last.delete();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'hFFFFFF; cmd_len = 8'd1;
    tick();
    cmd_valid = 1'b0;
    wait_idle("wrap_timeout");
    check("wrap_re_count", 32'(re_q.size()), 32'd2);
    if (re_q.size() >= 2) begin
      check("wrap_addr0", re_q[0], 32'h00FFFFFF);
      check("wrap_addr1", re_q[1], 32'h00000000);
    end
    if (beat_data.size() >= 2) begin
      check("wrap_data1", beat_data[1], 32'h0);
      check("wrap_last", 32'({beat_last[0], beat_last[1]}), 32'b01);
    end

    // reset in the middle of an eight-beat burst
    re_q.delete(); beat_data.delete(); beat_last.delete();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 24'h000200; cmd_len = 8'd7;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(rsp_valid && rsp_data == 32'h202) && n < 100) begin tick(); n++; end
    check("mr_reached_beat2", 32'(rsp_valid && rsp_data == 32'h202), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_rsp_last", 32'(rsp_last), 32'd0);
    check("mr_rsp_data", rsp_data, 32'd0);
    check("mr_gb_addr", 32'(gb_addr), 32'd0);
    check("mr_strobes", 32'({gb_we, gb_re}), 32'd0);
    check("mr_busy_ready", 32'({busy, cmd_ready}), 32'd0);
    snap_re = re_q.size();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("mr_no_new_re", 32'(re_q.size()), 32'(snap_re));
    check("mr_idle", 32'(busy), 32'd0);
    snap_we = we_cnt;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h0000AB; cmd_wdata = 32'h12345678;
    tick();
    cmd_valid = 1'b0;
    check("mr_wr_we", 32'(gb_we), 32'd1);
    tick();
    check("mr_wr_count", 32'(we_cnt - snap_we), 32'd1);
    check("mr_wr_addr", we_addr, 32'hAB);
    check("mr_wr_data", we_data, 32'h12345678);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
